tmr_pipeline_seu_monitor: RTL and testbench

//   Parametrised data pipeline with an integrated multi-source SEU event monitor.
//   - Data path: DEPTH-stage, WIDTH-bit shift pipeline with a valid bit and a stall enable.
//   - Monitor: counts rising edges of NERR TMR voter-mismatch flags in saturating per-source counters.
//   - Sits between triplicated logic and slow-control readout, which polls counters via a select port.

---
 rtl/tmr_seu_pkg.sv | 26 ++
 rtl/seu_sat_counter.sv | 42 ++++
 rtl/tmr_pipeline_seu_monitor.sv | 132 +++++++++++++
 tb/tb_tmr_pipeline_seu_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_seu_pkg.sv
`default_nettype none
// ============================================================================
// Package : tmr_seu_pkg
// Brief   : Shared defaults and helpers for the TMR pipeline / SEU monitor.
// Rev     : 1.0  initial release
// ============================================================================
package tmr_seu_pkg;

    localparam int c_defWidth    = 8;
    localparam int c_defDepth    = 4;
    localparam int c_defNerr     = 4;
    localparam int c_defCntWidth = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic longint cntMax(input int w);
        return (longint'(1) << w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seu_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : seu_sat_counter
// Brief  : Saturating event counter with a sticky "reached all-ones" flag.
// Rev    : 1.0  initial release
// ============================================================================
module seu_sat_counter
    import tmr_seu_pkg::*;
#(
    parameter int W = c_defCntWidth
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] c_max = W'(cntMax(W));
    localparam logic [W-1:0] c_one = W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            if (inc && (cnt != c_max)) begin
                cnt <= cnt + c_one;
            end
            // Flag rises on the same edge the count lands on all-ones
            if ((cnt == c_max) || (inc && (cnt == (c_max - c_one)))) begin
                sat <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmr_pipeline_seu_monitor.sv
`default_nettype none
// ============================================================================
// Module : tmr_pipeline_seu_monitor
// Brief  : Stallable data pipeline plus per-source SEU rising-edge counters.
// Rev    : 1.0  initial release
// ============================================================================
module tmr_pipeline_seu_monitor
    import tmr_seu_pkg::*;
#(
    parameter  int WIDTH       = c_defWidth,
    parameter  int DEPTH       = c_defDepth,
    parameter  int NERR        = c_defNerr,
    parameter  int SEUCNTWIDTH = c_defCntWidth,
    localparam int SELW        = (clog2(NERR) > 1) ? clog2(NERR) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [WIDTH-1:0]       d,
    input  logic                   dValid,
    output logic [WIDTH-1:0]       q,
    output logic                   qValid,
    input  logic [NERR-1:0]        tmrErr,
    input  logic                   seuCountClr,
    input  logic [SELW-1:0]        cntSel,
    output logic [SEUCNTWIDTH-1:0] seuCount,
    output logic [SEUCNTWIDTH-1:0] errCycles,
    output logic [NERR-1:0]        satFlag,
    output logic                   errPulse
);

    // Each stage carries {valid, data}
    logic [WIDTH:0] r_stage   [DEPTH];
    logic [WIDTH:0] w_stageIn [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_stageIn[i] = {dValid, d};
        end else begin : g_tail
            assign w_stageIn[i] = r_stage[i-1];
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_stage[i] <= '0;
            end else if (en) begin
                r_stage[i] <= w_stageIn[i];
            end
        end
    end

    assign q      = r_stage[DEPTH-1][WIDTH-1:0];
    assign qValid = r_stage[DEPTH-1][WIDTH];

    // Edge registers ignore seuCountClr so a level held across a clear is not recounted
    logic [NERR-1:0] r_errS;
    logic [NERR-1:0] r_errP;
    logic [NERR-1:0] w_ev;
    logic            w_anyEv;
    logic            r_errPulse;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_errS <= '0;
            r_errP <= '0;
        end else begin
            r_errS <= tmrErr;
            r_errP <= r_errS;
        end
    end

    assign w_ev    = r_errS & ~r_errP;
    assign w_anyEv = |w_ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_errPulse <= 1'b0;
        end else if (seuCountClr) begin
            r_errPulse <= 1'b0;
        end else begin
            r_errPulse <= w_anyEv;
        end
    end

    assign errPulse = r_errPulse;

    logic [SEUCNTWIDTH-1:0] w_cnt [NERR];
    logic                   w_unusedSat;

    for (genvar i = 0; i < NERR; i++) begin : g_src
        seu_sat_counter #(.W(SEUCNTWIDTH)) u_cnt (
            .clk  (clk),
            .rstn (rstn),
            .clr  (seuCountClr),
            .inc  (w_ev[i]),
            .cnt  (w_cnt[i]),
            .sat  (satFlag[i])
        );
    end

    seu_sat_counter #(.W(SEUCNTWIDTH)) u_errCycles (
        .clk  (clk),
        .rstn (rstn),
        .clr  (seuCountClr),
        .inc  (w_anyEv),
        .cnt  (errCycles),
        .sat  (w_unusedSat)
    );

    // Out-of-range selects fall through to zero
    logic [SEUCNTWIDTH-1:0] w_selCnt;
    logic [SEUCNTWIDTH-1:0] r_seuCount;

    always_comb begin
        w_selCnt = '0;
        for (int i = 0; i < NERR; i++) begin
            if (cntSel == SELW'(i)) w_selCnt = w_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seuCount <= '0;
        end else begin
            r_seuCount <= w_selCnt;
        end
    end

    assign seuCount = r_seuCount;

endmodule
`default_nettype wire

// File: tb/tb_tmr_pipeline_seu_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_tmr_pipeline_seu_monitor
// Brief  : Self-checking bench: vector table, random traffic vs model, corner cases.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tmr_pipeline_seu_monitor;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int N    = 5;
    localparam int CW   = 4;
    localparam int SW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          en = 1'b0;
    logic [W-1:0]  d = '0;
    logic          dValid = 1'b0;
    logic [N-1:0]  tmrErr = '0;
    logic          seuCountClr = 1'b0;
    logic [SW-1:0] cntSel = '0;
    logic [W-1:0]  q;
    logic          qValid;
    logic [CW-1:0] seuCount;
    logic [CW-1:0] errCycles;
    logic [N-1:0]  satFlag;
    logic          errPulse;

    tmr_pipeline_seu_monitor #(
        .WIDTH(W), .DEPTH(D), .NERR(N), .SEUCNTWIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .d(d), .dValid(dValid),
        .q(q), .qValid(qValid), .tmrErr(tmrErr), .seuCountClr(seuCountClr),
        .cntSel(cntSel), .seuCount(seuCount), .errCycles(errCycles),
        .satFlag(satFlag), .errPulse(errPulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: counts from the rise history of tmrErr, pipeline as a FIFO of accepted words
    int           mCnt [N];
    int           mCyc;
    logic [N-1:0] mSat;
    logic         mPulse;
    int           mSeu;
    logic [N-1:0] h1, h2;
    logic [W:0]   pq [$];

    task automatic modelReset();
        for (int i = 0; i < N; i++) mCnt[i] = 0;
        mCyc = 0; mSat = '0; mPulse = 1'b0; mSeu = 0;
        h1 = '0; h2 = '0;
        pq.delete();
    endtask

    task automatic tick();
        logic          sEn, sV, sClr;
        logic [W-1:0]  sD;
        logic [N-1:0]  sErr, ev;
        logic [SW-1:0] sSel;
        logic [W:0]    expItem;
        sEn = en; sV = dValid; sClr = seuCountClr; sD = d; sErr = tmrErr; sSel = cntSel;
        @(posedge clk);
        #1;
        ev = h1 & ~h2;
        mSeu = 0;
        if (int'(sSel) < N) mSeu = mCnt[sSel];
        if (sClr) begin
            for (int i = 0; i < N; i++) mCnt[i] = 0;
            mCyc = 0; mSat = '0; mPulse = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ev[i] && mCnt[i] < MAXC) mCnt[i] = mCnt[i] + 1;
                if (mCnt[i] == MAXC) mSat[i] = 1'b1;
            end
            if (ev != '0 && mCyc < MAXC) mCyc = mCyc + 1;
            mPulse = (ev != '0);
        end
        h2 = h1; h1 = sErr;
        if (sEn) begin
            pq.push_back({sV, sD});
            if (pq.size() > D) pq.delete(0);
        end
        expItem = (pq.size() == D) ? pq[0] : '0;
        chk("m_q",         32'(q),         32'(expItem[W-1:0]));
        chk("m_qValid",    32'(qValid),    32'(expItem[W]));
        chk("m_seuCount",  32'(seuCount),  32'(mSeu));
        chk("m_errCycles", 32'(errCycles), 32'(mCyc));
        chk("m_satFlag",   32'(satFlag),   32'(mSat));
        chk("m_errPulse",  32'(errPulse),  32'(mPulse));
    endtask

    task automatic clearAll();
        tmrErr = '0;
        repeat (3) tick();
        seuCountClr = 1'b1;
        tick();
        seuCountClr = 1'b0;
    endtask

    typedef struct {
        logic         en;
        logic [W-1:0] d;
        logic         dv;
        logic [W-1:0] expQ;
        logic         expV;
    } vec_t;

    vec_t tbl [9];
    int   expRd [N];

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h11, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h22, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h33, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h3C, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 8'h00, 1'b0, 8'hA5, 1'b1};
        tbl[7] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{1'b1, 8'h00, 1'b0, 8'h3C, 1'b1};
        expRd  = '{1, 1, 0, 1, 0};
        modelReset();

        // Power-on reset state
        #3 rstn = 1'b0;
        #1;
        chk("rst_q",         32'(q),         32'd0);
        chk("rst_qValid",    32'(qValid),    32'd0);
        chk("rst_seuCount",  32'(seuCount),  32'd0);
        chk("rst_errCycles", 32'(errCycles), 32'd0);
        chk("rst_satFlag",   32'(satFlag),   32'd0);
        chk("rst_errPulse",  32'(errPulse),  32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Latency and stall
        for (int j = 0; j < 9; j++) begin
            en = tbl[j].en; d = tbl[j].d; dValid = tbl[j].dv;
            tick();
            chk($sformatf("tbl%0d_q", j),      32'(q),      32'(tbl[j].expQ));
            chk($sformatf("tbl%0d_qValid", j), 32'(qValid), 32'(tbl[j].expV));
        end

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            en          = ($urandom_range(3) != 0);
            d           = W'($urandom);
            dValid      = 1'($urandom);
            cntSel      = SW'($urandom_range(7));
            seuCountClr = ($urandom_range(59) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) tmrErr[b] = ~tmrErr[b];
            end
            tick();
        end
        seuCountClr = 1'b0;

        // Asynchronous reset mid-run
        #2 rstn = 1'b0;
        #1;
        chk("arst_q",         32'(q),         32'd0);
        chk("arst_qValid",    32'(qValid),    32'd0);
        chk("arst_seuCount",  32'(seuCount),  32'd0);
        chk("arst_errCycles", 32'(errCycles), 32'd0);
        chk("arst_satFlag",   32'(satFlag),   32'd0);
        chk("arst_errPulse",  32'(errPulse),  32'd0);
        modelReset();
        tmrErr = '0; en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_q",      32'(q),      32'd0);
        chk("rel_qValid", 32'(qValid), 32'd0);
        en = 1'b1; d = 8'hFF; dValid = 1'b1;
        tick();
        en = 1'b0;

        // Level held high counts once per rise
        clearAll();
        tmrErr = 5'b00100;
        repeat (10) tick();
        tmrErr = '0;
        repeat (3) tick();
        tmrErr = 5'b00100;
        repeat (3) tick();
        tmrErr = '0;
        repeat (3) tick();
        cntSel = 3'd2;
        tick();
        chk("edge_seuCount",  32'(seuCount),  32'd2);
        chk("edge_errCycles", 32'(errCycles), 32'd2);

        // Saturation without wrap
        clearAll();
        for (int p = 0; p < 20; p++) begin
            tmrErr = 5'b00001; tick();
            tmrErr = '0;       tick();
        end
        repeat (3) tick();
        cntSel = 3'd0;
        tick();
        chk("sat_seuCount",  32'(seuCount),   32'd15);
        chk("sat_flag0",     32'(satFlag[0]), 32'd1);
        chk("sat_errCycles", 32'(errCycles),  32'd15);

        // Clear colliding with an event on source 1
        tmrErr = 5'b00010;
        tick();
        seuCountClr = 1'b1;
        tick();
        seuCountClr = 1'b0;
        chk("clr_errPulse", 32'(errPulse), 32'd0);
        chk("clr_satFlag",  32'(satFlag),  32'd0);
        repeat (4) tick();
        cntSel = 3'd1;
        tick();
        chk("clr_seuCount",  32'(seuCount),  32'd0);
        chk("clr_errCycles", 32'(errCycles), 32'd0);
        cntSel = 3'd5;
        tick();
        chk("clr_selOOR", 32'(seuCount), 32'd0);

        // Simultaneous rises on several sources
        clearAll();
        tmrErr = 5'b01011;
        tick();
        chk("sim_pulse_pre", 32'(errPulse), 32'd0);
        tick();
        chk("sim_pulse",     32'(errPulse),  32'd1);
        chk("sim_errCycles", 32'(errCycles), 32'd1);
        tick();
        chk("sim_pulse_post", 32'(errPulse), 32'd0);
        for (int i = 0; i < N; i++) begin
            cntSel = SW'(i);
            tick();
            chk($sformatf("sim_cnt%0d", i), 32'(seuCount), 32'(expRd[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
